// File: rtl/seven_segment_capture.sv
// seven_segment_capture
// Snoops a multiplexed, active-low 7-segment bus (segment pattern plus one-hot
// digit select) and rebuilds the hex nibble shown on each digit. Once every
// digit has been captured the whole frame is held for a consumer with a
// valid/ack handshake.
//
// Optional feature macro: SEVEN_SEGMENT_CAPTURE_BLANK_EN
//   When defined, the all-segments-off pattern is accepted as a blank digit
//   (stored as nibble 0) and the blank_o flags are added.
module seven_segment_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_i,
  input  logic [DIGITS-1:0]   dig_sel_i,
  input  logic                frame_ack_i,
  output logic [4*DIGITS-1:0] value_o,
  output logic                frame_valid_o,
  output logic [DIGITS-1:0]   err_o
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
  ,
  output logic [DIGITS-1:0]   blank_o
`endif
);

  // Parameter sanity: the dwell counter is 8 bits and the accept point sits
  // one step below saturation, so fewer than 2 cycles cannot work.
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("seven_segment_capture: STABLE_CYCLES must be within 2..255");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("seven_segment_capture: DIGITS must be at least 1");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Counter saturates here; an accept fires on the step that reaches MAX-1.
  localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES);
  localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 2);

  // Segment decoder: returns {decodable, nibble}. Patterns are active-low,
  // listed bit6 (middle) down to bit0 (top).
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0011000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Registered bus samples: current and previous, used for all comparisons.
  logic [6:0]        seg_q;
  logic [6:0]        seg_prev;
  logic [DIGITS-1:0] sel_q;
  logic [DIGITS-1:0] sel_prev;

  // Dwell tracking.
  logic [7:0]        cnt;
  logic              dwell_done;

  // Frame assembly state.
  state_t            state;
  logic [DIGITS-1:0] captured;

  // Combinational decode of the registered sample.
  logic              sel_onehot;
  logic              sample_same;
  logic              stable_now;
  logic              accept;
  logic              dec_ok;
  logic [3:0]        dec_nib;
  logic              pattern_ok;

  logic [DIGITS-1:0]   captured_nx;
  logic [4*DIGITS-1:0] value_nx;
  logic [DIGITS-1:0]   err_nx;

`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
  logic              is_blank;
  logic [DIGITS-1:0] blank_nx;

  assign is_blank = (seg_q == 7'b1111111);
`endif

  assign {dec_ok, dec_nib} = decode(seg_q);

`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
  assign pattern_ok = dec_ok | is_blank;
`else
  assign pattern_ok = dec_ok;
`endif

  assign sel_onehot  = $onehot(sel_q);
  assign sample_same = (seg_q == seg_prev) && (sel_q == sel_prev);
  assign stable_now  = sample_same && sel_onehot;

  // One accept per dwell: the counter passes ACCEPT_AT exactly once before
  // saturating, and dwell_done guards the same dwell against a second hit.
  assign accept = stable_now && (cnt == ACCEPT_AT) && !dwell_done &&
                  (state == COLLECT);

  // Input sampler: one register stage on the snooped bus, then a history tap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block (and the others) sees the pre-edge value of its source.
    if (!rst) begin
      // NOTE: the sample registers are reset too, so the first comparison
      // after reset sees an all-zero select (never one-hot) and cannot count
      // stale pre-reset pin history towards a dwell.
      seg_q    <= '0;
      seg_prev <= '0;
      sel_q    <= '0;
      sel_prev <= '0;
    end else begin
      seg_q    <= seg_i;
      seg_prev <= seg_q;
      sel_q    <= dig_sel_i;
      sel_prev <= sel_q;
    end
  end

  // Stability counter: counts identical one-hot samples, saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      dwell_done <= 1'b0;
    end else if (!stable_now) begin
      cnt        <= '0;
      dwell_done <= 1'b0;
    end else begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
      if (accept) begin
        dwell_done <= 1'b1;
      end
    end
  end

  // Next frame contents for an accept event on the selected digit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    captured_nx = captured;
    value_nx    = value_o;
    err_nx      = err_o;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
    blank_nx    = blank_o;
`endif
    if (accept) begin
      if (pattern_ok) begin
        captured_nx = captured | sel_q;
        for (int k = 0; k < DIGITS; k++) begin
          if (sel_q[k]) begin
            value_nx[4*k +: 4] = dec_nib;
          end
        end
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
        // A blank accept raises the flag; any other good accept clears it.
        blank_nx = is_blank ? (blank_o | sel_q) : (blank_o & ~sel_q);
`endif
      end else begin
        err_nx = err_o | sel_q;
      end
    end
  end

  // Frame FSM: collect digits, then hold the complete frame until acked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= COLLECT;
      captured      <= '0;
      value_o       <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
      blank_o       <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          captured <= captured_nx;
          value_o  <= value_nx;
          err_o    <= err_nx;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
          blank_o  <= blank_nx;
`endif
          // The write that completes the frame raises valid on the same edge,
          // so value_o and frame_valid_o always appear together.
          if (&captured_nx) begin
            state         <= HOLD;
            frame_valid_o <= 1'b1;
          end
        end
        HOLD: begin
          // value_o is left alone: the old frame stays visible until
          // individual digits are overwritten in the next collection.
          if (frame_ack_i) begin
            state         <= COLLECT;
            captured      <= '0;
            err_o         <= '0;
            frame_valid_o <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
            blank_o       <= '0;
`endif
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Inverse of the team's hex-to-segment encoder: snoops a multiplexed, active-low 7-segment bus (segment pattern plus one-hot digit select).
- Reconstructs the hex nibble shown on each digit and presents a complete multi-digit frame with a valid/ack handshake.
- Used on the maze board to read back what the HEX displays show (self-check, score/timer readback to logic).

Parameters:
- DIGITS, 4, number of multiplexed digits; frame width is 4*DIGITS.
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is accepted (range 2..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low: sampled on the rising edge of clk, and the block is in reset while rst==0.
- seg_i  input  7  segment pattern, active-low, bit0=top, bit1=upper-right, bit2=lower-right, bit3=bottom, bit4=lower-left, bit5=upper-left, bit6=middle
- dig_sel_i  input  DIGITS  one-hot active-high digit select; bit k = digit k (nibble k of the frame)
- frame_ack_i  input  1  consumer accepts the held frame
- value_o  output  4*DIGITS  decoded frame; nibble k = digit k
- frame_valid_o  output  1  value_o is a complete frame
- err_o  output  DIGITS  per-digit sticky flag: an undecodable pattern was seen on that digit this frame

Behaviour:
- Reset (rst==0 at a clk edge): value_o=0, frame_valid_o=0, err_o=0, captured mask=0, stable counter=0, dwell-done=0, state=COLLECT.
- Decode table (seg_i, active-low, listed bit6..bit0 -> nibble):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0011000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
  - Any other pattern is undecodable.
- Input sampling: seg_i and dig_sel_i are registered once (1 stage). All comparisons use the registered values.
- Stability counter:
  - Increments, saturating at STABLE_CYCLES, while the registered sample equals the previous registered sample and dig_sel is exactly one-hot.
  - Clears to 0, and clears dwell-done, when the sample changes, or dig_sel is zero or multi-hot.
- Accept event: fires on the cycle the counter reaches STABLE_CYCLES-1, with dwell-done==0 and state==COLLECT. It then sets dwell-done=1, so there is one accept per dwell.
  - Decodable pattern: store the nibble in slot k, set captured[k]. A re-accept of an already captured digit overwrites the nibble.
  - Undecodable pattern: set err_o[k]; nibble and captured[k] are unchanged.
- Latency: an accept occurs STABLE_CYCLES+1 clocks after a new stable value appears on the pins (1 input register + STABLE_CYCLES-1 compare cycles + 1 write).
- State machine (2 states):
  - COLLECT: accept events allowed. When captured becomes all-ones, the next state is HOLD and frame_valid_o=1 from the following cycle.
  - HOLD:
    - value_o and err_o are frozen and accept events are suppressed.
    - The stability counter keeps running, so a digit already stable at ack is not re-accepted until its dwell ends.
    - On frame_ack_i==1: clear captured and err_o, set frame_valid_o=0 next cycle, return to COLLECT. value_o retains the old frame until overwritten.
  - frame_ack_i in COLLECT is ignored.
- An accept can only occur in COLLECT and ack only matters in HOLD, so an accept and an ack cannot coincide.
- Reset mid-frame discards partial captures; reset during HOLD drops the frame without ack.

Optional Feature:
- Macro: SEVEN_SEGMENT_CAPTURE_BLANK_EN.
- Defined:
  - Pattern 1111111 (all segments off) is decodable as a blank digit: sets captured[k], stores nibble 0.
  - Adds output blank_o (DIGITS bits), with the same capture, freeze and clear rules as err_o.
  - A later non-blank accept on digit k clears blank_o[k].
- Undefined: 1111111 is undecodable (sets err_o[k]), and blank_o does not exist.

Test Plan:
- Reset behaviour: hold rst=0 for 3 clocks with random inputs -> value_o=0, frame_valid_o=0, err_o=0.
- Basic frame: DIGITS=4, STABLE_CYCLES=8; drive digits 0..3 with patterns for 4, 2, A, F, 12 clocks each -> frame_valid_o=1, value_o=16'hFA24; pulse ack -> frame_valid_o=0 next cycle.
- Stability filter: digit 0 shows 0100100 for 5 clocks, then 0110000 for 12 clocks -> nibble 0 = 3, never 2; one accept only (captured[0] set once, no overwrite glitch).
- Invalid pattern: digit 2 shows 0101010 for 12 clocks, others valid -> err_o=4'b0100, frame_valid_o stays 0. Then digit 2 shows 1000000 -> frame completes with nibble 2 = 0 and err_o=4'b0100 still visible.
- Select faults: dig_sel_i=4'b0011 or 4'b0000 for 50 clocks -> no captures, no err_o change.
- HOLD freeze and reset: complete frame 16'h1234, then drive new digits without ack -> value_o stays 16'h1234. Ack, then assert rst mid-collection -> all outputs return to 0.
